// File: rtl/tx_eq_pkg.sv
// Shared types and defaults for the TX equalization sweep sequencer.
// Holds the sweep state encoding and the accumulator width helper.
package tx_eq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      MEASURE,
      EVAL,
      FINAL
   } sweep_state_e;

   localparam int DEF_NUM_SETTINGS  = 8;
   localparam int DEF_SETTING_W     = 3;
   localparam int DEF_OPEN_W        = 12;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_AVG_LOG2      = 2;
   localparam int DEF_TIMEOUT       = 255;

   // Sum of 2^avg_log2 openings needs avg_log2 extra bits to never wrap.
   function automatic int acc_width(input int open_w, input int avg_log2);
      return open_w + avg_log2;
   endfunction

endpackage

// File: rtl/opening_avg.sv
// Accumulates eye-opening samples for one setting and flags when the
// sample set is complete or the reporting chain has gone quiet too long.
module opening_avg
   import tx_eq_pkg::*;
#(
   parameter int OPEN_W   = DEF_OPEN_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   localparam int ACC_W   = acc_width(OPEN_W, AVG_LOG2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              active,
   input  logic              opening_ready,
   input  logic [OPEN_W-1:0] opening,
   output logic [ACC_W-1:0]  acc,
   output logic [OPEN_W-1:0] avg,
   output logic              avg_valid,
   output logic              timeout
);

   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;
   logic [TO_W-1:0]  idle_cycles;

   // A sample arriving on the final idle cycle wins over the timeout.
   assign avg_valid = active && opening_ready && (count == LAST_SAMPLE);
   assign timeout   = active && !opening_ready && (idle_cycles == TO_LAST);
   assign avg       = acc[ACC_W-1:AVG_LOG2];

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         count       <= '0;
         idle_cycles <= '0;
      end else if (clear) begin
         acc         <= '0;
         count       <= '0;
         idle_cycles <= '0;
      end else if (active) begin
         if (opening_ready) begin
            acc         <= acc + ACC_W'(opening);
            count       <= count + 1'b1;
            idle_cycles <= '0;
         end else if (timeout) begin
            acc         <= '0;
            idle_cycles <= '0;
         end else begin
            idle_cycles <= idle_cycles + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_eq_sweep_ctrl.sv
// Steps the TX equalizer through every candidate setting, averages the
// reported eye openings and finally applies the widest-opening setting.
module tx_eq_sweep_ctrl
   import tx_eq_pkg::*;
#(
   parameter int NUM_SETTINGS  = DEF_NUM_SETTINGS,
   parameter int SETTING_W     = DEF_SETTING_W,
   parameter int OPEN_W        = DEF_OPEN_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int AVG_LOG2      = DEF_AVG_LOG2,
   parameter int TIMEOUT       = DEF_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 opening_ready,
   input  logic [OPEN_W-1:0]    opening,
   output logic [SETTING_W-1:0] setting_out,
   output logic                 setting_valid,
   output logic                 measure_en,
   output logic                 busy,
   output logic                 done,
   output logic [SETTING_W-1:0] best_setting,
   output logic [OPEN_W-1:0]    best_opening,
   output logic                 timeout_err
);

   localparam int ACC_W = acc_width(OPEN_W, AVG_LOG2);
   localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTING_W-1:0] LAST_IDX    = SETTING_W'(NUM_SETTINGS - 1);
   localparam logic [SC_W-1:0]      SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

   sweep_state_e         state, state_nxt;
   logic [SETTING_W-1:0] idx, idx_nxt;
   logic [SC_W-1:0]      settle_cnt, settle_cnt_nxt;
   logic [SETTING_W-1:0] best_setting_nxt, setting_out_nxt;
   logic [OPEN_W-1:0]    best_opening_nxt;
   logic                 timeout_err_nxt;

   logic                 meas_clear, meas_active, avg_valid, meas_timeout;
   logic [OPEN_W-1:0]    avg;
   // The raw sum is only of interest inside the averager.
   logic [ACC_W-1:0]     acc_unused;

   assign meas_active = (state == MEASURE);
   assign meas_clear  = (state == SETTLE) && (settle_cnt == '0);

   opening_avg #(
      .OPEN_W   (OPEN_W),
      .AVG_LOG2 (AVG_LOG2),
      .TIMEOUT  (TIMEOUT)
   ) u_opening_avg (
      .clk           (clk),
      .rst           (rst),
      .clear         (meas_clear),
      .active        (meas_active),
      .opening_ready (opening_ready),
      .opening       (opening),
      .acc           (acc_unused),
      .avg           (avg),
      .avg_valid     (avg_valid),
      .timeout       (meas_timeout)
   );

   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt        = state;
      idx_nxt          = idx;
      settle_cnt_nxt   = settle_cnt;
      best_setting_nxt = best_setting;
      best_opening_nxt = best_opening;
      timeout_err_nxt  = timeout_err;
      setting_out_nxt  = setting_out;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt        = APPLY;
               idx_nxt          = '0;
               best_setting_nxt = '0;
               best_opening_nxt = '0;
               timeout_err_nxt  = 1'b0;
            end
         end
         APPLY: begin
            settle_cnt_nxt = SETTLE_LOAD;
            state_nxt      = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt == '0) state_nxt = MEASURE;
            else                  settle_cnt_nxt = settle_cnt - 1'b1;
         end
         MEASURE: begin
            if (avg_valid) begin
               state_nxt = EVAL;
            end else if (meas_timeout) begin
               timeout_err_nxt = 1'b1;
               state_nxt       = EVAL;
            end
         end
         EVAL: begin
            // Strict compare: on a tie the earlier (lower) index stays best.
            if (avg > best_opening) begin
               best_opening_nxt = avg;
               best_setting_nxt = idx;
            end
            if (idx == LAST_IDX) begin
               state_nxt = FINAL;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = APPLY;
            end
         end
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == APPLY)      setting_out_nxt = idx_nxt;
      else if (state_nxt == FINAL) setting_out_nxt = best_setting_nxt;
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         settle_cnt    <= '0;
         setting_out   <= '0;
         setting_valid <= 1'b0;
         measure_en    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         best_setting  <= '0;
         best_opening  <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         settle_cnt    <= settle_cnt_nxt;
         setting_out   <= setting_out_nxt;
         setting_valid <= (state_nxt == APPLY) || (state_nxt == FINAL);
         measure_en    <= (state_nxt == MEASURE);
         busy          <= (state_nxt != IDLE);
         done          <= (state_nxt == FINAL);
         best_setting  <= best_setting_nxt;
         best_opening  <= best_opening_nxt;
         timeout_err   <= timeout_err_nxt;
      end
   end

endmodule

// File: tb/tb_tx_eq_sweep_ctrl.sv
// Directed bench for tx_eq_sweep_ctrl: four settings, four samples each,
// a ready strobe every third MEASURE cycle, and a 20-cycle timeout.
module tb_tx_eq_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        opening_ready;
   logic [11:0] opening;
   logic [2:0]  setting_out;
   logic        setting_valid;
   logic        measure_en;
   logic        busy;
   logic        done;
   logic [2:0]  best_setting;
   logic [11:0] best_opening;
   logic        timeout_err;

   int n_vec = 0;
   int n_err = 0;

   logic [11:0] samp [4][4];
   bit          silent [4];
   bit          noise;

   tx_eq_sweep_ctrl #(
      .NUM_SETTINGS  (4),
      .SETTING_W     (3),
      .OPEN_W        (12),
      .SETTLE_CYCLES (16),
      .AVG_LOG2      (2),
      .TIMEOUT       (20)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .opening_ready (opening_ready),
      .opening       (opening),
      .setting_out   (setting_out),
      .setting_valid (setting_valid),
      .measure_en    (measure_en),
      .busy          (busy),
      .done          (done),
      .best_setting  (best_setting),
      .best_opening  (best_opening),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_setting_out"},   32'(setting_out),   0);
      check({tag, "_setting_valid"}, 32'(setting_valid), 0);
      check({tag, "_measure_en"},    32'(measure_en),    0);
      check({tag, "_busy"},          32'(busy),          0);
      check({tag, "_done"},          32'(done),          0);
      check({tag, "_best_setting"},  32'(best_setting),  0);
      check({tag, "_best_opening"},  32'(best_opening),  0);
      check({tag, "_timeout_err"},   32'(timeout_err),   0);
   endtask

   task automatic fill(input int s, input logic [11:0] v);
      for (int k = 0; k < 4; k++) samp[s][k] = v;
   endtask

   // Runs one sweep from a start pulse. With stop_c > 0 it returns after
   // stop_c cycles without expecting completion.
   task automatic run_sweep(input string tag, input int stop_c, input int exp_best,
                            input int exp_open, input int exp_cycles, input bit exp_terr);
      int  meas [4];
      int  limit;
      int  cur, nxt, gap, k;
      bit  got;
      limit = (stop_c > 0) ? stop_c : 400;
      got = 0; cur = 0; nxt = 0; gap = 0; k = 0;
      for (int s = 0; s < 4; s++) meas[s] = 0;

      @(negedge clk);
      check({tag, "_idle_before_start"}, 32'(busy), 0);
      start = 1'b1;
      for (int c = 0; c < limit && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         opening_ready = 1'b0;
         if (c == 0) begin
            check({tag, "_apply0_valid"}, 32'(setting_valid), 1);
            check({tag, "_apply0_out"},   32'(setting_out),   0);
            check({tag, "_busy_first"},   32'(busy),          1);
            check({tag, "_terr_cleared"}, 32'(timeout_err),   0);
            check({tag, "_best_cleared"}, 32'(best_opening),  0);
         end
         if (done) begin
            got = 1;
            check({tag, "_done_cycle"},    c + 1,                exp_cycles);
            check({tag, "_final_valid"},   32'(setting_valid),   1);
            check({tag, "_final_out"},     32'(setting_out),     exp_best);
            check({tag, "_best_setting"},  32'(best_setting),    exp_best);
            check({tag, "_best_opening"},  32'(best_opening),    exp_open);
            check({tag, "_timeout_err"},   32'(timeout_err),     32'(exp_terr));
            check({tag, "_busy_at_final"}, 32'(busy),            1);
         end else begin
            if (setting_valid) begin
               check({tag, "_apply_order"}, 32'(setting_out), nxt);
               if (nxt < 4) begin
                  cur = nxt;
                  nxt++;
               end
               gap = 0;
               k = 0;
            end
            if (measure_en) begin
               meas[cur]++;
               gap++;
               if (!silent[cur] && gap == 3 && k < 4) begin
                  opening_ready = 1'b1;
                  opening = samp[cur][k];
                  k++;
                  gap = 0;
               end else if (noise && gap == 1) begin
                  start = 1'b1;
               end
            end else if (noise && busy && !setting_valid) begin
               opening_ready = 1'b1;
               opening = 12'hFFF;
            end
         end
      end

      if (stop_c <= 0) begin
         check({tag, "_done_seen"}, 32'(got), 1);
         for (int s = 0; s < 4; s++)
            check($sformatf("%s_measure_cycles_%0d", tag, s), meas[s], silent[s] ? 20 : 12);
         @(negedge clk);
         opening_ready = 1'b0;
         check({tag, "_busy_drop"},     32'(busy),          0);
         check({tag, "_done_pulse"},    32'(done),          0);
         check({tag, "_valid_pulse"},   32'(setting_valid), 0);
         check({tag, "_out_hold"},      32'(setting_out),   exp_best);
         check({tag, "_best_hold"},     32'(best_opening),  exp_open);
         check({tag, "_terr_sticky"},   32'(timeout_err),   32'(exp_terr));
      end
   endtask

   task automatic load_basic();
      fill(0, 12'd100);
      fill(1, 12'd300);
      fill(2, 12'd200);
      fill(3, 12'd50);
      for (int s = 0; s < 4; s++) silent[s] = 0;
      noise = 0;
   endtask

   initial begin
      int extra_done;
      rst = 1'b1;
      start = 1'b0;
      opening_ready = 1'b0;
      opening = '0;
      noise = 0;
      for (int s = 0; s < 4; s++) silent[s] = 0;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_reset");

      // Distinct openings: setting 1 wins with 300.
      load_basic();
      run_sweep("basic", 0, 1, 300, 121, 0);

      // Settings 2 and 3 both average 500: the lower index keeps it.
      fill(0, 12'd100);
      fill(1, 12'd100);
      fill(2, 12'd500);
      samp[3][0] = 12'd499; samp[3][1] = 12'd500;
      samp[3][2] = 12'd501; samp[3][3] = 12'd500;
      run_sweep("tie", 0, 2, 500, 121, 0);

      // 4010 / 4 floors to 1002; a rounding average would give 1003.
      fill(0, 12'd10);
      samp[1][0] = 12'd1001; samp[1][1] = 12'd1002;
      samp[1][2] = 12'd1003; samp[1][3] = 12'd1004;
      fill(2, 12'd1000);
      fill(3, 12'd10);
      run_sweep("floor", 0, 1, 1002, 121, 0);

      // Setting 1 never reports: 20-cycle MEASURE, sticky timeout flag.
      load_basic();
      fill(1, 12'd4000);
      silent[1] = 1;
      run_sweep("timeout", 0, 2, 200, 129, 1);

      // start during MEASURE and opening_ready outside MEASURE are ignored.
      load_basic();
      noise = 1;
      run_sweep("noise", 0, 1, 300, 121, 0);
      noise = 0;
      extra_done = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("noise_single_done", extra_done, 0);
      check("noise_idle_busy", 32'(busy), 0);

      // Reset in the middle of setting 2's settle window.
      load_basic();
      run_sweep("abort", 66, 0, 0, 0, 0);
      check("abort_mid_out",   32'(setting_out),  2);
      check("abort_mid_busy",  32'(busy),         1);
      check("abort_mid_meas",  32'(measure_en),   0);
      check("abort_mid_best",  32'(best_opening), 300);
      rst = 1'b1;
      #1;
      check_all_zero("abort_rst");
      @(negedge clk);
      rst = 1'b0;
      extra_done = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      check("abort_no_done", extra_done, 0);
      run_sweep("restart", 0, 1, 300, 121, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tx_eq_sweep_ctrl.md
# tx_eq_sweep_ctrl

Sequencer for the TX equalization channel-estimation loop. It steps the equalizer through every candidate setting, lets the channel settle, and enables the eye sampler/eye calculation path. It averages the reported eye openings per setting, then applies the setting with the widest average opening. It sits above the clock-shift/eye-sampling/eye-calculation chain and owns when measurements are taken and which setting the parameter-update stage drives.

## Interface
- NUM_SETTINGS, 8, number of candidate equalizer settings (2..2^SETTING_W)
- SETTING_W, 3, setting index width
- OPEN_W, 12, unsigned fixed-point eye-opening width
- SETTLE_CYCLES, 16, wait cycles after applying a setting (>=1)
- AVG_LOG2, 2, log2 of openings averaged per setting
- TIMEOUT, 255, max cycles allowed between opening_ready pulses

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sweep request pulse; honoured only in IDLE
- opening_ready  in  1  one-cycle strobe: opening is valid
- opening  in  OPEN_W  measured eye opening
- setting_out  out  SETTING_W  equalizer setting to apply
- setting_valid  out  1  one-cycle strobe: load setting_out
- measure_en  out  1  enables eye sampling/calculation
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sweep completion
- best_setting  out  SETTING_W  winning setting (valid at done)
- best_opening  out  OPEN_W  winning averaged opening
- timeout_err  out  1  sticky; set if any measurement timed out

## Operation
- FSM states: IDLE, APPLY, SETTLE, MEASURE, EVAL, FINAL.
- IDLE:
  - start=1 → APPLY.
  - On the same edge: idx=0, best_opening=0, best_setting=0, timeout_err=0.
- APPLY (1 cycle):
  - setting_out=idx, setting_valid=1.
  - Load settle counter with SETTLE_CYCLES-1, then → SETTLE.
- SETTLE:
  - Decrement the counter each cycle; on 0 → MEASURE.
  - On that transition, clear acc, sample count and timeout counter.
- MEASURE:
  - measure_en=1.
  - Each opening_ready: acc += opening, count++, timeout counter cleared.
  - When count reaches 2^AVG_LOG2 → EVAL.
  - Timeout counter increments on cycles without opening_ready. When it reaches TIMEOUT: set timeout_err, force acc=0, → EVAL.
- EVAL (1 cycle):
  - avg = acc >> AVG_LOG2.
  - If avg > best_opening (strict), update best_opening=avg and best_setting=idx. Ties keep the lower index.
  - If idx==NUM_SETTINGS-1 → FINAL; else idx++ and → APPLY.
- FINAL (1 cycle):
  - setting_out=best_setting, setting_valid=1, done=1.
  - → IDLE.
- Arithmetic: acc is OPEN_W+AVG_LOG2 bits unsigned and cannot overflow. avg is truncated (floor).
- opening_ready is ignored outside MEASURE.
- start is ignored while busy.
- setting_out holds its last value in all states other than APPLY/FINAL.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Internal counters, acc and idx cleared.
- All outputs are registered and change only on clk edges, except on rst assertion.
- Start at edge T: APPLY (setting_valid=1, setting_out=0) in cycle T+1. busy=1 from T+1 through the FINAL cycle.
- Per-setting latency: 1 (APPLY) + SETTLE_CYCLES + M (MEASURE cycles, M≥2^AVG_LOG2) + 1 (EVAL).
- FINAL is the cycle after the last EVAL. done and setting_valid are high together there; busy drops the following cycle.
- opening_ready on the cycle that completes the count is accumulated; the state is EVAL next cycle.
- Timeout and opening_ready in the same cycle: the sample is accumulated, no timeout.
- rst mid-sweep: immediate return to IDLE and all outputs 0. No done is issued.

## Structure
- Package tx_eq_pkg:
  - State enum sweep_state_e.
  - Default parameter constants.
  - Function to compute acc width (OPEN_W+AVG_LOG2).
- Sub-module opening_avg: accumulator, sample counter and timeout counter. It exposes acc, avg, avg_valid and timeout.
- The FSM and best-tracking registers stay in the top module.

## Test plan
- NUM_SETTINGS=4, AVG_LOG2=2; openings 100/300/200/50 per setting (4 samples each, 1 ready every 3 cycles) → done with best_setting=1, best_opening=300; final setting_valid with setting_out=1.
- Settings 2 and 3 both average 500 (others 100) → best_setting=2 (tie keeps lower index).
- Samples 1001,1002,1003,1004 for one setting → avg=1002 (floor of 4010/4).
- No opening_ready for setting 1, TIMEOUT=20 → EVAL exactly 20 cycles after MEASURE entry; timeout_err=1; setting 1 is never best; sweep still completes.
- start pulsed during MEASURE and opening_ready pulsed during SETTLE → both ignored; acc unaffected; only one done.
- rst asserted mid-SETTLE of setting 2 → all outputs 0 immediately; a new start restarts from setting 0 with correct results.
